// File: rtl/dmem_stall_responder.sv
//==============================================================================
// Module     : dmem_stall_responder
// Description: Multi-cycle word RAM for the MEM stage. It stalls the pipeline
//              while an access is in flight and pulses AckM when the access
//              completes. Optional macro DMEM_MISALIGN_TRAP_EN rejects
//              misaligned requests.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_stall_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AckM,
  output logic        MisalignM
);

  localparam int          c_AW        = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  c_BUSY_CNT  = 3'((LATENCY > 2) ? (LATENCY - 3) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_wr;
  logic [c_AW-1:0]   r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_req;
  logic              w_idle;
  logic              w_mis;
  logic              w_accept;
  logic              w_enter_done;
  logic [c_AW-1:0]   w_idx;
  logic              w_op_wr;
  logic [c_AW-1:0]   w_op_idx;
  logic [31:0]       w_op_data;
  logic              w_unused_addr;

  assign w_req  = MemReadM | MemWriteM;
  assign w_idle = (r_state == S_IDLE);
  assign w_idx  = ALUResultM[c_AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis  = w_idle & w_req & (ALUResultM[1:0] != 2'b00);
`else
  assign w_mis  = 1'b0;
`endif

  assign w_unused_addr = ^{ALUResultM[31:c_AW+2], ALUResultM[1:0]};

  assign w_accept  = w_idle & w_req & ~w_mis;
  assign StallM    = ~reset & (w_accept | (r_state == S_BUSY));
  assign MisalignM = ~reset & w_mis;

  // With LATENCY==2 the commit happens on the accept edge, so use live inputs.
  assign w_enter_done = (w_accept & (LATENCY == 2)) |
                        ((r_state == S_BUSY) & (r_cnt == 3'd0));
  assign w_op_wr   = w_idle ? MemWriteM  : r_wr;
  assign w_op_idx  = w_idle ? w_idx      : r_idx;
  assign w_op_data = w_idle ? WriteDataM : r_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_wr      <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      ReadDataM <= 32'd0;
      AckM      <= 1'b0;
    end else begin
      AckM <= w_enter_done;
      if (w_enter_done) begin
        if (w_op_wr) r_mem[w_op_idx] <= w_op_data;
        else         ReadDataM       <= r_mem[w_op_idx];
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr    <= MemWriteM;
            r_idx   <= w_idx;
            r_wdata <= WriteDataM;
            r_cnt   <= c_BUSY_CNT;
            r_state <= (LATENCY == 2) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 3'd0) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_stall_responder.sv
//==============================================================================
// Module     : tb_dmem_stall_responder
// Description: Directed bench for dmem_stall_responder at LATENCY 3 and 2.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_stall_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, ack, mis;
  logic        b_rd, b_wr;
  logic [31:0] b_addr, b_wdata;
  logic [31:0] b_rdata;
  logic        b_stall, b_ack, b_mis;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_stall_responder #(.DEPTH_WORDS(64), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .MemReadM(rd), .MemWriteM(wr),
    .ALUResultM(addr), .WriteDataM(wdata), .ReadDataM(rdata),
    .StallM(stall), .AckM(ack), .MisalignM(mis)
  );

  dmem_stall_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .MemReadM(b_rd), .MemWriteM(b_wr),
    .ALUResultM(b_addr), .WriteDataM(b_wdata), .ReadDataM(b_rdata),
    .StallM(b_stall), .AckM(b_ack), .MisalignM(b_mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full LATENCY=3 access with the request held until the DONE cycle.
  task automatic acc3(input string tag, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    chk({tag, "_stall_T"}, {31'd0, stall}, 32'd1);
    chk({tag, "_ack_T"},   {31'd0, ack},   32'd0);
    tick();
    addr = 32'hFFFF_FFFC; wdata = 32'h0;
    #1;
    chk({tag, "_stall_T1"}, {31'd0, stall}, 32'd1);
    chk({tag, "_ack_T1"},   {31'd0, ack},   32'd0);
    tick();
    chk({tag, "_stall_T2"}, {31'd0, stall}, 32'd0);
    chk({tag, "_ack_T2"},   {31'd0, ack},   32'd1);
    chk({tag, "_rdata_T2"}, rdata, exp_rd);
    chk({tag, "_mis"},      {31'd0, mis},   32'd0);
    rd = 1'b0; wr = 1'b0;
    tick();
    chk({tag, "_ack_idle"},   {31'd0, ack},   32'd0);
    chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rd = 1'b1; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    b_rd = 1'b1; b_wr = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack",   {31'd0, ack},   32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mis",   {31'd0, mis},   32'd0);
    chk("rst_stall2", {31'd0, b_stall}, 32'd0);
    rd = 1'b0; b_rd = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_ack",   {31'd0, ack},   32'd0);

    // LATENCY=2: request held through DONE is accepted once
    b_wr = 1'b1; b_addr = 32'h8; b_wdata = 32'h55AA_0011;
    #1;
    chk("l2_stall_T", {31'd0, b_stall}, 32'd1);
    tick();
    b_wr = 1'b0; b_rd = 1'b1;
    #1;
    chk("l2_stall_done", {31'd0, b_stall}, 32'd0);
    chk("l2_ack_done",   {31'd0, b_ack},   32'd1);
    tick();
    chk("l2_stall_new", {31'd0, b_stall}, 32'd1);
    chk("l2_ack_new",   {31'd0, b_ack},   32'd0);
    tick();
    chk("l2_ack_rd",   {31'd0, b_ack},   32'd1);
    chk("l2_rdata",    b_rdata, 32'h55AA_0011);
    b_rd = 1'b0;
    tick();
    chk("l2_ack_end",  {31'd0, b_ack},   32'd0);
    chk("l2_stall_end", {31'd0, b_stall}, 32'd0);

    // LATENCY=3 write then read back
    acc3("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
    acc3("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    // both strobes: treated as a write, read data untouched
    acc3("both30", 1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, 32'hDEAD_BEEF);
    acc3("rd30", 1'b1, 1'b0, 32'h30, 32'h0, 32'h0BAD_F00D);
    // address wrap modulo 256 bytes
    acc3("wr100", 1'b0, 1'b1, 32'h100, 32'h1234_5678, 32'h0BAD_F00D);
    acc3("rd000", 1'b1, 1'b0, 32'h000, 32'h0, 32'h1234_5678);

    // reset mid-access aborts the pending write
    acc3("wr20", 1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, 32'h1234_5678);
    rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF;
    tick();
    reset = 1'b1;
    #1;
    chk("rstmid_rdata", rdata, 32'h0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    wr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    acc3("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5_A5A5);

    // misaligned read of 0x13
`ifdef DMEM_MISALIGN_TRAP_EN
    rd = 1'b1; addr = 32'h13;
    #1;
    chk("mis_flag",  {31'd0, mis},   32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_ack",   {31'd0, ack},   32'd0);
    tick();
    chk("mis_rdata", rdata, 32'hA5A5_A5A5);
    rd = 1'b0;
    tick();
`else
    acc3("rd13", 1'b1, 1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
